// File: rtl/irq_arbiter.sv
// irq_arbiter: 32-source interrupt arbiter. Sources are captured into a
// pending register, masked, and the highest-numbered eligible one is offered
// to the core over a valid/ack handshake. The arbiter then tracks one
// in-service interrupt until the core retires it with a matching EOI.
module irq_arbiter #(
    parameter logic [31:0] EDGE_MASK = 32'h0000_0000  // 1 = rising-edge source, 0 = level source
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] irq_in,
    input  logic        mask_we,
    input  logic [31:0] mask_wdata,
    input  logic        req_ack,
    input  logic        eoi_valid,
    input  logic [4:0]  eoi_code,
    output logic        req_valid,
    output logic [4:0]  req_code,
    output logic        busy,
    output logic [31:0] pending
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OFFER   = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] irq_q;
    logic [31:0] mask;
    logic [4:0]  inservice_code;
    logic [31:0] inservice_onehot;
    logic [31:0] eligible;
    logic [4:0]  code;
    logic        accept;

    // An offer is consumed only while it is actually being offered.
    assign accept = (state == OFFER) && req_ack;

    // Registered copy of the raw lines, used for edge detection and level pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q <= '0;
        end else begin
            irq_q <= irq_in;
        end
    end

    // Mask register; a write takes effect for arbitration from the next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask <= '0;
        end else if (mask_we) begin
            mask <= mask_wdata;
        end
    end

    // Per-source pending state: level sources mirror irq_q, edge sources latch
    // a rising edge and hold it until their own offer is accepted.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_src
            if (EDGE_MASK[gi]) begin : g_edge
                logic edge_pend;
                // A new rising edge in the accept cycle keeps the bit set.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        edge_pend <= 1'b0;
                    end else if (irq_in[gi] && !irq_q[gi]) begin
                        edge_pend <= 1'b1;
                    end else if (accept && (req_code == 5'(gi))) begin
                        edge_pend <= 1'b0;
                    end
                end
                assign pending[gi] = edge_pend;
            end else begin : g_level
                assign pending[gi] = irq_q[gi];
            end
            assign inservice_onehot[gi] = busy && (inservice_code == 5'(gi));
        end
    endgenerate

    assign eligible = pending & mask & ~inservice_onehot;

    // Priority encode: the last set bit seen in an ascending scan is the highest.
    always_comb begin
        code = '0;
        for (int i = 0; i < 32; i++) begin
            if (eligible[i]) begin
                code = 5'(i);
            end
        end
    end

    // Offer / service FSM with registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            req_valid      <= 1'b0;
            req_code       <= '0;
            busy           <= 1'b0;
            inservice_code <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (eligible != '0) begin
                        req_code  <= code;
                        req_valid <= 1'b1;
                        state     <= OFFER;
                    end
                end
                OFFER: begin
                    // req_code stays frozen here even if the source goes away.
                    if (req_ack) begin
                        req_valid      <= 1'b0;
                        busy           <= 1'b1;
                        inservice_code <= req_code;
                        state          <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (eoi_valid && (eoi_code == inservice_code)) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_arbiter.sv
// Bench for irq_arbiter: a directed vector table, a hand-written reset
// sequence, then random traffic compared against a behavioural model.
module tb_irq_arbiter;

    localparam logic [31:0] EDGE = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] irq_in = '0;
    logic        mask_we = 1'b0;
    logic [31:0] mask_wdata = '0;
    logic        req_ack = 1'b0;
    logic        eoi_valid = 1'b0;
    logic [4:0]  eoi_code = '0;
    logic        req_valid;
    logic [4:0]  req_code;
    logic        busy;
    logic [31:0] pending;

    int errors = 0;
    int checks = 0;

    irq_arbiter #(.EDGE_MASK(EDGE)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .req_ack    (req_ack),
        .eoi_valid  (eoi_valid),
        .eoi_code   (eoi_code),
        .req_valid  (req_valid),
        .req_code   (req_code),
        .busy       (busy),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    int          m_phase;     // 0 waiting, 1 offering, 2 servicing
    logic [31:0] m_lines;     // last sampled raw lines
    logic [31:0] m_latched;   // captured edge events
    logic [31:0] m_enable;
    logic [4:0]  m_offer;
    logic [4:0]  m_isr;

    function automatic logic [31:0] m_pending();
        return (m_lines & ~EDGE) | (m_latched & EDGE);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_lines = '0; m_latched = '0; m_enable = '0; m_offer = '0; m_isr = '0;
    endtask

    // One clock edge of the model, evaluated with the current inputs.
    task automatic model_step();
        logic [31:0] cand;
        int best;
        cand = m_pending() & m_enable;
        if (m_phase == 2) cand[m_isr] = 1'b0;
        best = -1;
        for (int i = 31; i >= 0; i--) begin
            if (cand[i]) begin best = i; break; end
        end
        if (m_phase == 1 && req_ack) m_latched[m_offer] = 1'b0;
        m_latched = m_latched | (irq_in & ~m_lines & EDGE);
        case (m_phase)
            0: if (best >= 0) begin m_offer = 5'(best); m_phase = 1; end
            1: if (req_ack) begin m_isr = m_offer; m_phase = 2; end
            default: if (eoi_valid && eoi_code == m_isr) m_phase = 0;
        endcase
        m_lines = irq_in;
        if (mask_we) m_enable = mask_wdata;
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once.
    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check("rst req_valid", 32'(req_valid), 32'd0);
        check("rst req_code", 32'(req_code), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst pending", pending, 32'd0);
        #3;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [31:0] irq;
        logic        mwe;
        logic [31:0] mdata;
        logic        ack;
        logic        eoi;
        logic [4:0]  ecode;
        logic        ev;
        logic [4:0]  ec;
        logic        eb;
        logic [31:0] ep;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [31:0] irq, logic mwe, logic [31:0] mdata, logic ack,
                                logic eoi, logic [4:0] ecode, logic ev, logic [4:0] ec,
                                logic eb, logic [31:0] ep);
        vec_t r;
        r.irq = irq; r.mwe = mwe; r.mdata = mdata; r.ack = ack; r.eoi = eoi; r.ecode = ecode;
        r.ev = ev; r.ec = ec; r.eb = eb; r.ep = ep;
        return r;
    endfunction

    initial begin
        //                 irq           we  wdata        ack eoi code  rv  code busy pending
        vecs.push_back(mk(32'h0000_0001, 1, 32'hFFFF_FFFF, 0, 0, 0,    0,  0, 0, 32'h0000_0001));
        vecs.push_back(mk(32'h0000_0001, 0, 0,             0, 0, 0,    1,  0, 0, 32'h0000_0001));
        vecs.push_back(mk(32'h0000_0001, 0, 0,             1, 0, 0,    0,  0, 1, 32'h0000_0001));
        vecs.push_back(mk(32'h0000_0000, 0, 0,             0, 1, 0,    0,  0, 0, 32'h0000_0000));
        vecs.push_back(mk(32'h0000_0000, 0, 0,             0, 0, 0,    0,  0, 0, 32'h0000_0000));
        vecs.push_back(mk(32'h8000_0010, 0, 0,             0, 0, 0,    0,  0, 0, 32'h8000_0010));
        vecs.push_back(mk(32'h8000_0010, 0, 0,             0, 0, 0,    1, 31, 0, 32'h8000_0010));
        vecs.push_back(mk(32'h8000_0010, 0, 0,             1, 0, 0,    0, 31, 1, 32'h8000_0010));
        vecs.push_back(mk(32'h0000_0010, 0, 0,             0, 1, 31,   0, 31, 0, 32'h0000_0010));
        vecs.push_back(mk(32'h0000_0010, 0, 0,             0, 0, 0,    1,  4, 0, 32'h0000_0010));
        vecs.push_back(mk(32'h0000_0010, 0, 0,             1, 0, 0,    0,  4, 1, 32'h0000_0010));
        vecs.push_back(mk(32'h0000_0000, 0, 0,             0, 1, 4,    0,  4, 0, 32'h0000_0000));
        vecs.push_back(mk(32'h0000_0020, 0, 0,             0, 0, 0,    0,  4, 0, 32'h0000_0020));
        vecs.push_back(mk(32'h0000_0020, 0, 0,             0, 0, 0,    1,  5, 0, 32'h0000_0020));
        vecs.push_back(mk(32'h0000_0020, 0, 0,             1, 0, 0,    0,  5, 1, 32'h0000_0020));
        vecs.push_back(mk(32'h0000_0020, 0, 0,             0, 1, 6,    0,  5, 1, 32'h0000_0020));
        vecs.push_back(mk(32'h0000_0000, 0, 0,             0, 1, 5,    0,  5, 0, 32'h0000_0000));
        vecs.push_back(mk(32'h0000_0000, 0, 0,             1, 0, 0,    0,  5, 0, 32'h0000_0000));
        vecs.push_back(mk(32'h0000_0000, 0, 0,             1, 1, 5,    0,  5, 0, 32'h0000_0000));
        vecs.push_back(mk(32'hFFFF_FFFF, 1, 32'h0,         0, 0, 0,    0,  5, 0, 32'hFFFF_FFFF));
        vecs.push_back(mk(32'hFFFF_FFFF, 0, 0,             0, 0, 0,    0,  5, 0, 32'hFFFF_FFFF));
        vecs.push_back(mk(32'hFFFF_FFFF, 1, 32'h0000_0400, 0, 0, 0,    0,  5, 0, 32'hFFFF_FFFF));
        vecs.push_back(mk(32'hFFFF_FFFF, 0, 0,             0, 0, 0,    1, 10, 0, 32'hFFFF_FFFF));
        vecs.push_back(mk(32'hFFFF_FFFF, 1, 32'h0,         0, 0, 0,    1, 10, 0, 32'hFFFF_FFFF));
        vecs.push_back(mk(32'h0000_0000, 0, 0,             0, 0, 0,    1, 10, 0, 32'h0000_0100));
        vecs.push_back(mk(32'h0000_0000, 0, 0,             1, 0, 0,    0, 10, 1, 32'h0000_0100));
        vecs.push_back(mk(32'h0000_0000, 0, 0,             0, 1, 10,   0, 10, 0, 32'h0000_0100));
        vecs.push_back(mk(32'h0000_0000, 0, 0,             0, 0, 0,    0, 10, 0, 32'h0000_0100));
        vecs.push_back(mk(32'h0000_0000, 1, 32'h0000_0100, 0, 0, 0,    0, 10, 0, 32'h0000_0100));
        vecs.push_back(mk(32'h0000_0000, 0, 0,             0, 0, 0,    1,  8, 0, 32'h0000_0100));
        vecs.push_back(mk(32'h0000_0000, 0, 0,             1, 0, 0,    0,  8, 1, 32'h0000_0000));
        vecs.push_back(mk(32'h0000_0100, 0, 0,             0, 0, 0,    0,  8, 1, 32'h0000_0100));
        vecs.push_back(mk(32'h0000_0000, 0, 0,             0, 0, 0,    0,  8, 1, 32'h0000_0100));
        vecs.push_back(mk(32'h0000_0000, 0, 0,             0, 1, 8,    0,  8, 0, 32'h0000_0100));
        vecs.push_back(mk(32'h0000_0000, 0, 0,             0, 0, 0,    1,  8, 0, 32'h0000_0100));
        vecs.push_back(mk(32'h0000_0000, 0, 0,             1, 0, 0,    0,  8, 1, 32'h0000_0000));
        vecs.push_back(mk(32'h0000_0000, 0, 0,             0, 1, 8,    0,  8, 0, 32'h0000_0000));
        vecs.push_back(mk(32'h0000_0100, 0, 0,             0, 0, 0,    0,  8, 0, 32'h0000_0100));
        vecs.push_back(mk(32'h0000_0000, 0, 0,             0, 0, 0,    1,  8, 0, 32'h0000_0100));
        vecs.push_back(mk(32'h0000_0100, 0, 0,             1, 0, 0,    0,  8, 1, 32'h0000_0100));
        vecs.push_back(mk(32'h0000_0000, 0, 0,             0, 1, 8,    0,  8, 0, 32'h0000_0100));
        vecs.push_back(mk(32'h0000_0000, 0, 0,             0, 0, 0,    1,  8, 0, 32'h0000_0100));
        vecs.push_back(mk(32'h0000_0000, 0, 0,             1, 0, 0,    0,  8, 1, 32'h0000_0000));
        vecs.push_back(mk(32'h0000_0000, 0, 0,             0, 1, 8,    0,  8, 0, 32'h0000_0000));

        @(posedge clk);
        #1;
        do_reset();

        // Directed vector table.
        for (int i = 0; i < vecs.size(); i++) begin
            irq_in = vecs[i].irq; mask_we = vecs[i].mwe; mask_wdata = vecs[i].mdata;
            req_ack = vecs[i].ack; eoi_valid = vecs[i].eoi; eoi_code = vecs[i].ecode;
            tick();
            check($sformatf("vec%0d req_valid", i), 32'(req_valid), 32'(vecs[i].ev));
            check($sformatf("vec%0d req_code", i), 32'(req_code), 32'(vecs[i].ec));
            check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].eb));
            check($sformatf("vec%0d pending", i), pending, vecs[i].ep);
            $display("vec %0d irq=%h rv=%0d code=%0d busy=%0d pend=%h", i, irq_in, req_valid, req_code, busy, pending);
        end
        mask_we = 0; req_ack = 0; eoi_valid = 0;

        // Reset while an offer is outstanding, then re-arm via the mask.
        irq_in = 32'h0000_0001; mask_we = 1; mask_wdata = 32'hFFFF_FFFF;
        tick();
        mask_we = 0;
        tick();
        check("pre-rst offer", 32'(req_valid), 32'd1);
        do_reset();
        tick();
        check("re-pend after rst", pending, 32'h0000_0001);
        check("no offer after rst", 32'(req_valid), 32'd0);
        tick(); tick();
        check("mask cleared by rst", 32'(req_valid), 32'd0);
        mask_we = 1; mask_wdata = 32'h0000_0001;
        tick();
        mask_we = 0;
        check("old mask on write", 32'(req_valid), 32'd0);
        tick();
        check("offer after mask rewrite", 32'(req_valid), 32'd1);
        check("code after mask rewrite", 32'(req_code), 32'd0);
        $display("rst seq rv=%0d code=%0d pend=%h", req_valid, req_code, pending);
        req_ack = 1;
        tick();
        req_ack = 0; irq_in = 0; eoi_valid = 1; eoi_code = 0;
        tick();
        eoi_valid = 0;

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            irq_in     = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & $urandom & $urandom);
            mask_we    = ($urandom_range(0, 15) == 0);
            mask_wdata = ($urandom_range(0, 1) == 1) ? $urandom : 32'hFFFF_FFFF;
            req_ack    = ($urandom_range(0, 1) == 1);
            eoi_valid  = ($urandom_range(0, 9) < 4);
            eoi_code   = ($urandom_range(0, 1) == 1) ? m_isr : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                tick();
                check($sformatf("rnd%0d req_valid", n), 32'(req_valid), 32'(m_phase == 1));
                check($sformatf("rnd%0d req_code", n), 32'(req_code), 32'(m_offer));
                check($sformatf("rnd%0d busy", n), 32'(busy), 32'(m_phase == 2));
                check($sformatf("rnd%0d pending", n), pending, m_pending());
                $display("rnd %0d irq=%h rv=%0d code=%0d busy=%0d pend=%h", n, irq_in, req_valid, req_code, busy, pending);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
